// File: rtl/decode_issue_stage.sv
// Decode / register-read stage: decodes the instruction, bypasses writeback data,
// stalls on RAW/WAW hazards using a pending-write scoreboard, and issues into a valid/ready output register.
module decode_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              id_ready,
    output logic [SEL_W-1:0]  rf_read_sel1,
    output logic [SEL_W-1:0]  rf_read_sel2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_en,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [SEL_W-1:0]  ex_dest,
    output logic              ex_wen,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct
);

    localparam int unsigned NREG = 2 ** SEL_W;

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [SEL_W-1:0]  w_rs;
    logic [SEL_W-1:0]  w_rt;
    logic [SEL_W-1:0]  w_rd;
    logic              w_use_rs;
    logic              w_use_rt;
    logic              w_has_dest;
    logic [SEL_W-1:0]  w_dest_field;
    logic [SEL_W-1:0]  w_dest;
    logic              w_wen;
    logic              w_zext;
    logic [DATA_W-1:0] w_imm;
    logic              w_rs_haz;
    logic              w_rt_haz;
    logic              w_dest_haz;
    logic              w_hazard;
    logic              w_accept;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic [NREG-1:0]   w_pending_nxt;

    logic [NREG-1:0]   r_pending;
    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_opa;
    logic [DATA_W-1:0] r_ex_opb;
    logic [DATA_W-1:0] r_ex_imm;
    logic [SEL_W-1:0]  r_ex_dest;
    logic              r_ex_wen;
    logic [5:0]        r_ex_opcode;
    logic [5:0]        r_ex_funct;

    assign w_opcode = if_instr[31:26];
    assign w_funct  = if_instr[5:0];
    assign w_rs     = SEL_W'(if_instr[25:21]);
    assign w_rt     = SEL_W'(if_instr[20:16]);
    assign w_rd     = SEL_W'(if_instr[15:11]);

    assign rf_read_sel1 = w_rs;
    assign rf_read_sel2 = w_rt;

    // Source usage and destination selection by opcode class; unknown opcodes decode as NOP
    always_comb begin
        w_use_rs     = 1'b0;
        w_use_rt     = 1'b0;
        w_has_dest   = 1'b0;
        w_dest_field = '0;
        case (w_opcode)
            6'h00: begin
                w_use_rs     = 1'b1;
                w_use_rt     = 1'b1;
                w_has_dest   = 1'b1;
                w_dest_field = w_rd;
            end
            6'h23: begin
                w_use_rs     = 1'b1;
                w_has_dest   = 1'b1;
                w_dest_field = w_rt;
            end
            6'h2B, 6'h04, 6'h05: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_use_rs     = 1'b1;
                w_has_dest   = 1'b1;
                w_dest_field = w_rt;
            end
            default: begin
            end
        endcase
    end

    assign w_dest = w_has_dest ? w_dest_field : '0;
    assign w_wen  = w_has_dest && (w_dest_field != '0);

    assign w_zext = (w_opcode == 6'h0C) || (w_opcode == 6'h0D) || (w_opcode == 6'h0E);
    assign w_imm  = w_zext ? DATA_W'(if_instr[15:0])
                           : {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

    // A same-cycle writeback to a pending register resolves that hazard
    assign w_rs_haz   = w_use_rs && (w_rs != '0) && r_pending[w_rs]
                        && !(wb_en && (wb_sel == w_rs));
    assign w_rt_haz   = w_use_rt && (w_rt != '0) && r_pending[w_rt]
                        && !(wb_en && (wb_sel == w_rt));
    assign w_dest_haz = w_wen && r_pending[w_dest] && !(wb_en && (wb_sel == w_dest));
    assign w_hazard   = w_rs_haz || w_rt_haz || w_dest_haz;

    assign id_ready = !w_hazard && (!r_ex_valid || ex_ready) && !flush;
    assign w_accept = if_valid && id_ready;

    assign w_opa = (wb_en && (wb_sel == w_rs) && (w_rs != '0)) ? wb_data : rf_read_data1;
    assign w_opb = (wb_en && (wb_sel == w_rt) && (w_rt != '0)) ? wb_data : rf_read_data2;

    // Scoreboard update: clears first so a same-cycle set wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_en) begin
            w_pending_nxt[wb_sel] = 1'b0;
        end
        if (flush && r_ex_valid && r_ex_wen) begin
            w_pending_nxt[r_ex_dest] = 1'b0;
        end
        if (w_accept && w_wen) begin
            w_pending_nxt[w_dest] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending   <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_opa    <= '0;
            r_ex_opb    <= '0;
            r_ex_imm    <= '0;
            r_ex_dest   <= '0;
            r_ex_wen    <= 1'b0;
            r_ex_opcode <= '0;
            r_ex_funct  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid  <= 1'b1;
                r_ex_opa    <= w_opa;
                r_ex_opb    <= w_opb;
                r_ex_imm    <= w_imm;
                r_ex_dest   <= w_dest;
                r_ex_wen    <= w_wen;
                r_ex_opcode <= w_opcode;
                r_ex_funct  <= w_funct;
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_opA    = r_ex_opa;
    assign ex_opB    = r_ex_opb;
    assign ex_imm    = r_ex_imm;
    assign ex_dest   = r_ex_dest;
    assign ex_wen    = r_ex_wen;
    assign ex_opcode = r_ex_opcode;
    assign ex_funct  = r_ex_funct;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed scenarios followed by random traffic,
// checked against a behavioural model of decode, bypass and in-flight destinations.
module tb_decode_issue_stage;

    logic        clock;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic [4:0]  rf_read_sel1;
    logic [4:0]  rf_read_sel2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_wen;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        wen;
        logic [5:0]  op;
        logic [5:0]  fn;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    logic [31:0] rf [32];
    bit    m_pend [32];
    bit    m_valid = 1'b0;
    exp_t  m_cur;
    exp_t  q [$];
    bit    last_acc;

    decode_issue_stage #(.DATA_W(32), .SEL_W(5)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .rf_read_sel1(rf_read_sel1), .rf_read_sel2(rf_read_sel2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_wen(ex_wen),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment register file: async read, written by the writeback port
    assign rf_read_data1 = rf[rf_read_sel1];
    assign rf_read_data2 = rf[rf_read_sel2];
    always @(posedge clock) begin
        if (!reset && wb_en && wb_sel != 5'd0) rf[wb_sel] <= wb_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics as a table of what each opcode reads and writes
    function automatic void decode(input logic [31:0] ins, output bit urs, output bit urt,
                                   output logic [4:0] d, output bit w, output logic [31:0] imm);
        logic [5:0] op;
        bit hasd;
        op = ins[31:26];
        urs = 0; urt = 0; hasd = 0; d = 5'd0;
        if (op == 6'h00) begin urs = 1; urt = 1; hasd = 1; d = ins[15:11]; end
        else if (op == 6'h23 || (op >= 6'h08 && op <= 6'h0F)) begin urs = 1; hasd = 1; d = ins[20:16]; end
        else if (op == 6'h2B || op == 6'h04 || op == 6'h05) begin urs = 1; urt = 1; end
        w = hasd && (d != 5'd0);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) imm = {16'h0, ins[15:0]};
        else imm = {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] src);
        if (wb_en && wb_sel == src && src != 5'd0) return wb_data;
        return rf[src];
    endfunction

    function automatic bit src_haz(input bit used, input logic [4:0] src);
        return used && src != 5'd0 && m_pend[src] && !(wb_en && wb_sel == src);
    endfunction

    // One clock: compare handshake at negedge, advance the model at the posedge
    task automatic step();
        bit urs, urt, w, haz, rdy, acc;
        logic [4:0] rs, rt, d;
        logic [31:0] imm;
        exp_t e;
        @(negedge clock);
        decode(if_instr, urs, urt, d, w, imm);
        rs = if_instr[25:21];
        rt = if_instr[20:16];
        haz = src_haz(urs, rs) || src_haz(urt, rt) || (w && m_pend[d] && !(wb_en && wb_sel == d));
        rdy = !haz && (!m_valid || ex_ready) && !flush;
        chk("id_ready", id_ready, rdy);
        chk("ex_valid", ex_valid, m_valid);
        chk("rf_sel", {rf_read_sel1, rf_read_sel2}, {rs, rt});
        acc = if_valid && rdy;
        e = '{a: operand(rs), b: operand(rt), imm: imm, dest: d, wen: w,
              op: if_instr[31:26], fn: if_instr[5:0]};
        last_acc = acc && !reset;
        @(posedge clock);
        if (reset) begin
            m_valid = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
            q.delete();
        end else begin
            if (wb_en) m_pend[wb_sel] = 0;
            if (flush && m_valid && m_cur.wen) m_pend[m_cur.dest] = 0;
            if (acc && w) m_pend[d] = 1;
            m_pend[0] = 0;
            if (flush) m_valid = 0;
            else if (acc) begin m_valid = 1; m_cur = e; q.push_back(e); end
            else if (ex_ready) m_valid = 0;
        end
        #1;
    endtask

    // Monitor: whenever an instruction is presented it must match the oldest issued one
    always @(negedge clock) begin
        if (!reset && ex_valid) begin
            if (q.size() == 0) begin
                chk("ex_unexpected", 64'd1, 64'd0);
            end else begin
                chk("ex_opA", ex_opA, q[0].a);
                chk("ex_opB", ex_opB, q[0].b);
                chk("ex_imm", ex_imm, q[0].imm);
                chk("ex_ctl", {ex_dest, ex_wen, ex_opcode, ex_funct},
                    {q[0].dest, q[0].wen, q[0].op, q[0].fn});
                if (flush || ex_ready) void'(q.pop_front());
            end
        end
    end

    task automatic wb(input logic [4:0] sel);
        wb_en = 1; wb_sel = sel; wb_data = $urandom;
        step();
        wb_en = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [16];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h3F, 6'h10};
        return {ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    initial begin
        bit have;
        logic [4:0] pend_list [$];
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 0; rf[1] = 5; rf[2] = 7;
        reset = 1; if_valid = 0; if_instr = 0; wb_en = 0; wb_sel = 0; wb_data = 0;
        flush = 0; ex_ready = 1;
        step(); step();
        chk("rst_fields", {ex_valid, ex_opA, ex_dest, ex_wen, ex_opcode, ex_funct}, 64'd0);
        chk("rst_opB_imm", {ex_opB, ex_imm}, 64'd0);
        reset = 0;

        // ADD r3,r1,r2
        if_valid = 1; if_instr = 32'h00221820; step();
        if_valid = 0;
        chk("add_ops", {ex_opA, ex_opB}, {32'd5, 32'd7});
        chk("add_dest", {ex_dest, ex_wen}, {5'd3, 1'b1});

        // SUB r4,r3,r1 waits on r3 until its writeback, then bypasses
        if_valid = 1; if_instr = 32'h00612022;
        repeat (3) begin step(); chk("raw_stall", id_ready, 0); end
        wb_en = 1; wb_sel = 3; wb_data = 32'h2A; #1;
        chk("raw_release", id_ready, 1);
        step();
        wb_en = 0; if_valid = 0;
        chk("bypass_opA", ex_opA, 32'h2A);
        chk("sub_opB_dest", {ex_opB, ex_dest}, {32'd5, 5'd4});
        wb(4);

        // Immediate extension and writes to r0
        if_valid = 1; if_instr = 32'h2005FFFF; step();
        chk("addi_imm", ex_imm, 32'hFFFFFFFF);
        if_instr = 32'h3405FFFF; wb_en = 1; wb_sel = 5; wb_data = $urandom; step();
        chk("ori_imm", ex_imm, 32'h0000FFFF);
        if_instr = 32'h00220020; wb_data = $urandom; step();
        wb_en = 0; if_valid = 0;
        chk("r0_wen", {ex_dest, ex_wen}, 6'd0);
        step();

        // Backpressure: output held, then the next instruction loads once EX is ready
        ex_ready = 0; if_valid = 1; if_instr = 32'h00224820; step();
        if_instr = 32'h202A0003;
        repeat (3) begin step(); chk("hold_stall", {id_ready, ex_dest}, {1'b0, 5'd9}); end
        ex_ready = 1; #1;
        chk("hold_release", id_ready, 1);
        step();
        if_valid = 0;
        chk("hold_next", ex_dest, 5'd10);
        wb(9); wb(10);

        // Flush kills LW r6 and its pending destination
        if_valid = 1; if_instr = 32'h8C260000; step();
        if_valid = 0; flush = 1; step();
        flush = 0;
        chk("flush_valid", ex_valid, 0);
        if_valid = 1; if_instr = 32'h00C13820; #1;
        chk("flush_nostall", id_ready, 1);
        step();
        if_valid = 0;
        chk("after_flush_dest", ex_dest, 5'd7);
        wb(7);

        // Reset during a hazard stall
        if_valid = 1; if_instr = 32'h00224020; step();
        if_instr = 32'h01012022;
        repeat (2) begin step(); chk("rst_stall", id_ready, 0); end
        reset = 1; step();
        reset = 0;
        chk("rst_mid_valid", ex_valid, 0);
        chk("rst_mid_ready", id_ready, 1);
        step();
        if_valid = 0;
        chk("rst_mid_accept", {ex_valid, ex_dest}, {1'b1, 5'd4});
        wb(4);

        // Random traffic
        have = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 9) < 7) begin have = 1; if_instr = rand_instr(); end
            if_valid = have;
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 5) begin
                pend_list.delete();
                for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(5'(r));
                wb_en = 1; wb_data = $urandom;
                if (pend_list.size() > 0 && $urandom_range(0, 9) < 8)
                    wb_sel = pend_list[$urandom_range(0, pend_list.size() - 1)];
                else
                    wb_sel = 5'($urandom_range(0, 31));
            end else begin
                wb_en = 0;
            end
            step();
            if (last_acc) have = 0;
        end
        if_valid = 0; flush = 0; reset = 0; wb_en = 0; ex_ready = 1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode / register-read stage. It sits directly upstream of the 32x32 register file and feeds the execute stage.
- Decodes a 32-bit MIPS-style instruction and drives the register-file read selects.
- Bypasses same-cycle writeback data and tracks in-flight destinations with a per-register scoreboard, stalling on RAW/WAW hazards.
- Issues operands to EX through a valid/ready pipeline register.

Parameters:
DATA_W, 32, operand/data width
SEL_W, 5, register select width (2**SEL_W registers)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_valid  in  1  fetch presents instruction
if_instr  in  32  instruction; held stable while if_valid && !id_ready
id_ready  out  1  stage accepts instruction this cycle (combinational)
rf_read_sel1  out  SEL_W  = if_instr[25:21] (rs), combinational
rf_read_sel2  out  SEL_W  = if_instr[20:16] (rt), combinational
rf_read_data1  in  DATA_W  register file async read port 1
rf_read_data2  in  DATA_W  register file async read port 2
wb_en  in  1  writeback this cycle (same signals drive regfile write port)
wb_sel  in  SEL_W  writeback destination
wb_data  in  DATA_W  writeback value
flush  in  1  kill instruction held in output register
ex_valid  out  1  output register holds valid instruction
ex_ready  in  1  EX consumes output this cycle
ex_opA, ex_opB  out  DATA_W  captured rs/rt operand values
ex_imm  out  DATA_W  extended immediate
ex_dest  out  SEL_W  destination register
ex_wen  out  1  instruction writes ex_dest
ex_opcode, ex_funct  out  6 each  if_instr[31:26], [5:0]

Behaviour:
- Decode by opcode:
  - 0x00 R-type: uses rs, rt; dest = rd [15:11].
  - 0x23 LW: uses rs; dest = rt.
  - 0x2B SW: uses rs, rt; no dest.
  - 0x04/0x05 BEQ/BNE: uses rs, rt; no dest.
  - 0x08-0x0F ALU-immediate: uses rs; dest = rt.
  - 0x02 J: no sources, no dest.
  - Any other opcode: NOP (no sources, no dest, ex_wen = 0).
- Dest 0 forces wen = 0. Source 0 is never a hazard and always reads 0.
- Immediate: zero-extend [15:0] for 0x0C/0x0D/0x0E; sign-extend for everything else.
- Bypass: if wb_en && wb_sel == src && src != 0, operand = wb_data; otherwise operand = rf_read_data. Unused sources capture the regfile value unchanged.
- Scoreboard pending[0..31], one bit per register.
  - hazard = any used source with its pending bit set and not cleared by this cycle's writeback, OR (wen && pending[dest] && !(wb_en && wb_sel == dest)).
  - id_ready = !hazard && (!ex_valid || ex_ready) && !flush.
- Accept = if_valid && id_ready. On accept, all ex_* fields load next edge, ex_valid <= 1.
- If ex_valid && ex_ready && !accept, then ex_valid <= 0 next edge.
- Output fields are held stable while ex_valid && !ex_ready.
- Pending update each edge, in this order:
  1. Clear pending[wb_sel] if wb_en.
  2. Set pending[dest] on accept with wen.
  3. Clear pending[ex_dest] on flush if ex_valid && ex_wen.
  - Set wins over clear for the same register in the same cycle.
  - pending[0] is always 0.
- Flush: ex_valid <= 0 next edge; no accept that cycle. Flush has priority over ex_ready.
- Reset: ex_valid = 0, all ex_* = 0, all pending = 0. Reset overrides accept, flush and writeback. Reset mid-stall discards the held instruction.
- Latency: one cycle from accept to ex_valid. Throughput is one instruction per cycle with no hazards.

Test Plan:
- Reset, then regfile r1 = 5, r2 = 7. Issue ADD r3,r1,r2 (0x00221820) with ex_ready = 1 -> next cycle ex_valid = 1, ex_opA = 5, ex_opB = 7, ex_dest = 3, ex_wen = 1, pending[3] = 1.
- Issue ADD r3,r1,r2, then SUB r4,r3,r1 with no writeback -> id_ready = 0 for every cycle until wb_en = 1, wb_sel = 3, wb_data = 0x2A. That cycle it accepts with ex_opA = 0x2A via bypass; pending[3] = 0, pending[4] = 1.
- ADDI r5,r0,-1 (0x2005FFFF) -> ex_imm = 0xFFFFFFFF. ORI r5,r0,0xFFFF (0x3405FFFF) -> ex_imm = 0x0000FFFF. Write to r0 (ADD r0,r1,r2) -> ex_wen = 0, pending unchanged.
- Hold ex_ready = 0 with ex_valid = 1 and a new if_valid -> id_ready = 0 and ex_* stable for 3 cycles. Raise ex_ready -> the next instruction loads the following edge.
- Issue LW r6,0(r1), then assert flush while ex_valid -> ex_valid = 0 and pending[6] = 0 next cycle. A subsequent ADD r7,r6,r1 is accepted without stall.
- Assert reset while a hazard stall is active -> ex_valid = 0 and all pending = 0 next cycle; the stalled instruction is accepted on the first cycle after reset deasserts.
